p4s1_buf: RTL and testbench
===========================

P4S1_BUF -- requirements
Module: p4s1_buf

Interface
REQ-001 Parameter WORDLENGTH, default 16, width of every data word.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  advance enable for the serial output side.
REQ-005 in_valid  input  1  parallel group presented on data_in0..3.
REQ-006 in_ready  output  1  pending buffer empty; a group is accepted when in_valid and in_ready are both 1.
REQ-007 data_in0, data_in1, data_in2, data_in3  input  WORDLENGTH each  parallel group; data_in3 is the oldest word.
REQ-008 data_out  output  WORDLENGTH  serial word, registered.
REQ-009 out_valid  output  1  data_out holds a valid word this cycle.
REQ-010 out_counter  output  2  slot index of data_out: 0 = first word, 3 = last word of its group.
REQ-011 sop  output  1  high with the first word (out_counter=0) of each group.

Function
REQ-012 Storage: one pending buffer (4 words plus pend_valid) and one active shift buffer (4 words, act_valid, 2-bit slot count cnt).
REQ-013 in_ready is a registered output equal to NOT pend_valid; the block never accepts a group while pend_valid=1.
REQ-014 Acceptance is independent of enable: an accepted group is written to the pending buffer and sets pend_valid at the next edge.
REQ-015 Emission order within a group: data_in3, data_in2, data_in1, data_in0, on consecutive enabled cycles, with out_counter 0, 1, 2, 3.
REQ-016 States: IDLE (act_valid=0) and SHIFT (act_valid=1).
REQ-017 IDLE with enable=1 and pend_valid=1: copy pending to active, set cnt=0, clear pend_valid, go to SHIFT; out_valid=0 this cycle.
REQ-018 SHIFT with enable=1: drive data_out with the active word for slot cnt, set out_valid=1, out_counter=cnt, sop=(cnt==0), then increment cnt.
REQ-019 SHIFT with enable=1 and cnt=3, with pend_valid=1: copy pending to active, set cnt=0, clear pend_valid, stay in SHIFT. Back-to-back groups are emitted with no gap.
REQ-020 SHIFT with enable=1 and cnt=3, with pend_valid=0: go to IDLE.
REQ-021 A group accepted in the same cycle pend_valid clears is impossible (in_ready is registered); in_ready rises the following cycle.
REQ-022 enable=0: cnt, state and active buffer hold. out_valid and sop are 0. data_out and out_counter hold their last values. The pending buffer may still fill.
REQ-023 Latency: a group accepted at edge t, into an idle block with enable held at 1, gives its first out_valid word at edge t+2.
REQ-024 Throughput: the block sustains one word per cycle if the source presents each next group within 3 cycles of in_ready rising.
REQ-025 out_counter and out_valid together drive a downstream 4:1 serial-to-parallel stage directly; that stage latches the group on out_counter=3.
REQ-026 No arithmetic is performed; words pass bit-exact at WORDLENGTH.

Reset
REQ-027 With rst=0, all of the following clear immediately and asynchronously: data_out=0, out_valid=0, out_counter=0, sop=0, in_ready=0, pend_valid=0, act_valid=0, cnt=0, and both buffers to 0.
REQ-028 On the first edge after rst deasserts, in_ready becomes 1.
REQ-029 Reset mid-group discards both buffers; no partial group resumes after reset.

Verification
REQ-030 Single group: enable=1, accept {in3..in0}={0x0004,0x0003,0x0002,0x0001} -> data_out 0x0004, 0x0003, 0x0002, 0x0001 at t+2..t+5; out_counter 0..3; sop only at t+2.
REQ-031 Back-to-back: groups A=0x10..0x13 and B=0x20..0x23 accepted as soon as in_ready allows -> 8 contiguous out_valid cycles, order 0x13, 0x12, 0x11, 0x10, 0x23, 0x22, 0x21, 0x20.
REQ-032 Stall: enable=0 for 3 cycles after the second word -> out_valid=0 and data_out holds the second word during the stall; the remaining two words follow with no loss or duplication.
REQ-033 Full: pending and active both occupied -> in_ready=0; an in_valid pulse with 0xDEAD data is ignored and never appears on data_out.
REQ-034 Reset mid-shift: assert rst at out_counter=1 -> all outputs 0 immediately; after release, in_ready=1 and no stale word is emitted.
REQ-035 Loopback: feed data_out, out_counter and out_valid into a 4:1 serial-to-parallel stage -> its parallel outputs equal the original data_in0..3 for 100 random groups.

Source files
------------

// File: rtl/p4s1_buf.sv
// 4:1 parallel-to-serial buffer: one pending group plus one shifting group, so
// back-to-back groups stream out with no gap between them.
module p4s1_buf #(
  parameter int WORDLENGTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDLENGTH-1:0] data_in0,
  input  logic [WORDLENGTH-1:0] data_in1,
  input  logic [WORDLENGTH-1:0] data_in2,
  input  logic [WORDLENGTH-1:0] data_in3,
  output logic [WORDLENGTH-1:0] data_out,
  output logic                  out_valid,
  output logic [1:0]            out_counter,
  output logic                  sop
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                         r_state;
  logic [3:0][WORDLENGTH-1:0]     r_pend;
  logic [3:0][WORDLENGTH-1:0]     r_act;
  logic                           r_pendValid;
  logic [1:0]                     r_cnt;
  logic                           r_inReady;
  logic [WORDLENGTH-1:0]          r_dataOut;
  logic                           r_outValid;
  logic [1:0]                     r_outCounter;
  logic                           r_sop;

  logic w_accept;
  logic w_load;
  logic w_pendValidNext;

  // Accept and load are mutually exclusive: accept needs an empty pending slot,
  // load needs a full one, so the pending buffer never sees both in one cycle.
  assign w_accept        = in_valid && r_inReady;
  assign w_load          = enable && r_pendValid && ((r_state == IDLE) || (r_cnt == 2'd3));
  assign w_pendValidNext = (r_pendValid && !w_load) || w_accept;

  // Slot 0 of each buffer holds data_in3, the oldest word, so it leaves first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pend       <= '0;
      r_act        <= '0;
      r_pendValid  <= 1'b0;
      r_cnt        <= 2'd0;
      r_inReady    <= 1'b0;
      r_dataOut    <= '0;
      r_outValid   <= 1'b0;
      r_outCounter <= 2'd0;
      r_sop        <= 1'b0;
    end else begin
      r_outValid  <= 1'b0;
      r_sop       <= 1'b0;
      r_pendValid <= w_pendValidNext;
      r_inReady   <= !w_pendValidNext;
      if (w_accept) begin
        r_pend <= {data_in0, data_in1, data_in2, data_in3};
      end
      if (enable) begin
        case (r_state)
          IDLE: begin
            if (r_pendValid) begin
              r_act   <= r_pend;
              r_cnt   <= 2'd0;
              r_state <= SHIFT;
            end
          end
          SHIFT: begin
            r_dataOut    <= r_act[r_cnt];
            r_outValid   <= 1'b1;
            r_outCounter <= r_cnt;
            r_sop        <= (r_cnt == 2'd0);
            r_cnt        <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_pendValid) begin
                r_act <= r_pend;
                r_cnt <= 2'd0;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready    = r_inReady;
  assign data_out    = r_dataOut;
  assign out_valid   = r_outValid;
  assign out_counter = r_outCounter;
  assign sop         = r_sop;

endmodule

// File: tb/tb_p4s1_buf.sv
// Self-checking bench for p4s1_buf: directed scenarios plus a random loopback run
// against a word/group queue model and a behavioural 4:1 serial-to-parallel stage.
module tb_p4s1_buf;

  localparam int WL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] data_in0, data_in1, data_in2, data_in3;
  logic [WL-1:0] data_out;
  logic          out_valid;
  logic [1:0]    out_counter;
  logic          sop;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [WL-1:0]   wordQ[$];
  logic [4*WL-1:0] groupQ[$];
  logic [WL-1:0]   s2p[4];
  int              monPos  = 0;
  int              runLen  = 0;
  int              lastRun = 0;
  bit              randEn  = 1'b0;

  p4s1_buf #(.WORDLENGTH(WL)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out(data_out), .out_valid(out_valid), .out_counter(out_counter), .sop(sop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: every handshake queues its four words oldest-first; each emitted word
  // must be the next in line, with slot position and sop derived from the model.
  always @(negedge clk) begin
    if (!rst) begin
      wordQ.delete();
      groupQ.delete();
      monPos = 0;
      runLen = 0;
    end else begin
      if (out_valid) begin
        runLen++;
        if (wordQ.size() == 0) begin
          checkOutput("spurious_word", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          checkOutput("data_out", 64'(data_out), 64'(wordQ.pop_front()));
          checkOutput("out_counter", 64'(out_counter), 64'(monPos));
          checkOutput("sop", 64'(sop), 64'(monPos == 0));
          s2p[out_counter] = data_out;
          if (out_counter == 2'd3 && groupQ.size() > 0)
            checkOutput("loopback", 64'({s2p[3], s2p[2], s2p[1], s2p[0]}), 64'(groupQ.pop_front()));
          monPos = (monPos + 1) % 4;
        end
      end else if (runLen != 0) begin
        lastRun = runLen;
        runLen  = 0;
      end
      if (in_valid && in_ready) begin
        wordQ.push_back(data_in3);
        wordQ.push_back(data_in2);
        wordQ.push_back(data_in1);
        wordQ.push_back(data_in0);
        groupQ.push_back({data_in0, data_in1, data_in2, data_in3});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (randEn) enable = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input logic v, input logic [WL-1:0] d3, input logic [WL-1:0] d2,
                               input logic [WL-1:0] d1, input logic [WL-1:0] d0);
    in_valid = v;
    data_in3 = d3;
    data_in2 = d2;
    data_in1 = d1;
    data_in0 = d0;
  endtask

  task automatic sendGroup(input logic [WL-1:0] d3, input logic [WL-1:0] d2,
                           input logic [WL-1:0] d1, input logic [WL-1:0] d0);
    bit accepted = 1'b0;
    applyStimulus(1'b1, d3, d2, d1, d0);
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        cycle();
        accepted = 1'b1;
        break;
      end
      cycle();
    end
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("send_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic waitIdle(input int budget);
    bit idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!out_valid && wordQ.size() == 0) begin
        idle = 1'b1;
        break;
      end
      cycle();
    end
    checkOutput("drain_idle", 64'(idle), 64'd1);
  endtask

  task automatic waitSlot1();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_counter == 2'd1) begin
        seen = 1'b1;
        break;
      end
      cycle();
    end
    checkOutput("reach_slot1", 64'(seen), 64'd1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0);
    #2 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_counter", 64'(out_counter), 64'd0);
    checkOutput("rst_sop", 64'(sop), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    checkOutput("in_ready_after_rst", 64'(in_ready), 64'd1);

    $display("[TB] single group latency");
    enable = 1'b1;
    applyStimulus(1'b1, 16'h0004, 16'h0003, 16'h0002, 16'h0001);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("single_t0_valid", 64'(out_valid), 64'd0);
    cycle();
    checkOutput("single_t1_valid", 64'(out_valid), 64'd0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      checkOutput("single_valid", 64'(out_valid), 64'd1);
      checkOutput("single_data", 64'(data_out), 64'(4 - k));
      checkOutput("single_slot", 64'(out_counter), 64'(k));
      checkOutput("single_sop", 64'(sop), 64'(k == 0));
      cycle();
    end
    checkOutput("single_end_valid", 64'(out_valid), 64'd0);

    $display("[TB] back-to-back groups");
    waitIdle(20);
    sendGroup(16'h0013, 16'h0012, 16'h0011, 16'h0010);
    sendGroup(16'h0023, 16'h0022, 16'h0021, 16'h0020);
    waitIdle(30);
    cycle();
    checkOutput("b2b_run_length", 64'(lastRun), 64'd8);

    $display("[TB] stall");
    sendGroup(16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0);
    waitSlot1();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("stall_valid", 64'(out_valid), 64'd0);
      checkOutput("stall_sop", 64'(sop), 64'd0);
      checkOutput("stall_data_hold", 64'(data_out), 64'h00C2);
      checkOutput("stall_slot_hold", 64'(out_counter), 64'd1);
    end
    enable = 1'b1;
    cycle();
    checkOutput("resume_data2", 64'(data_out), 64'h00C1);
    checkOutput("resume_slot2", 64'(out_counter), 64'd2);
    cycle();
    checkOutput("resume_data3", 64'(data_out), 64'h00C0);
    checkOutput("resume_slot3", 64'(out_counter), 64'd3);
    cycle();
    checkOutput("resume_end_valid", 64'(out_valid), 64'd0);

    $display("[TB] full buffers");
    waitIdle(20);
    checkOutput("full_pre_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0);
    cycle();
    applyStimulus(1'b0, '0, '0, '0, '0);
    cycle();
    enable = 1'b0;
    sendGroup(16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    cycle();
    cycle();
    checkOutput("full_in_ready_held", 64'(in_ready), 64'd0);
    checkOutput("full_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, '0);
    enable = 1'b1;
    waitIdle(30);
    checkOutput("full_queue_empty", 64'(groupQ.size()), 64'd0);

    $display("[TB] reset mid-shift");
    sendGroup(16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0);
    waitSlot1();
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_data_out", 64'(data_out), 64'd0);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_counter", 64'(out_counter), 64'd0);
    checkOutput("midrst_sop", 64'(sop), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    checkOutput("midrst_ready_after", 64'(in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);
      cycle();
    end

    $display("[TB] random loopback");
    randEn = 1'b1;
    for (int g = 0; g < 100; g++) begin
      repeat ($urandom_range(0, 2)) cycle();
      sendGroup(WL'($urandom), WL'($urandom), WL'($urandom), WL'($urandom));
    end
    randEn = 1'b0;
    enable = 1'b1;
    waitIdle(60);
    cycle();
    checkOutput("loopback_groups_left", 64'(groupQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
